// File: rtl/coeff_sched_pkg.sv
// Shared types and constants for the coefficient bank scheduler.
package coeff_sched_pkg;

    localparam int NUM_TAPS   = 16;
    localparam int BANK_W     = 2;
    localparam int CMD_IDX_W  = $clog2(NUM_TAPS);
    localparam int CMD_DATA_W = 16;

    typedef enum logic [1:0] {
        AXIS_X   = 2'd0,
        AXIS_Y   = 2'd1,
        AXIS_Z   = 2'd2,
        AXIS_INV = 2'd3
    } axis_t;

    // One queued coefficient update, head of FIFO maps straight onto cw_*.
    typedef struct packed {
        axis_t                  axis;
        logic [BANK_W-1:0]      bank;
        logic [CMD_IDX_W-1:0]   index;
        logic [CMD_DATA_W-1:0]  value;
    } coeff_cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/coeff_cmd_fifo.sv
// Small synchronous FIFO of coefficient commands. Full/empty come from the
// count held in the register, i.e. the value before this cycle's update.
module coeff_cmd_fifo
    import coeff_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  coeff_cmd_t       wr_data,
    output coeff_cmd_t       rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    coeff_cmd_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == LVL_W'(DEPTH));
    assign empty     = (r_count == LVL_W'(0));
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign rd_data   = r_mem[r_rd_ptr];
    assign level     = r_count;

    // Pointer and occupancy bookkeeping; push+pop together keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= LVL_W'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Command storage, cleared on reset so a flushed FIFO holds no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/coeff_bank_scheduler.sv
// Turns CPU coefficient-update commands into single-cycle RAM writes issued
// while the filter is idle, and switches x/y/z banks atomically at a sample
// boundary once all queued writes have drained.
module coeff_bank_scheduler
    import coeff_sched_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    parameter  int DATA_W     = 16,
    parameter  int IDX_W      = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              update_en,
    input  logic [1:0]        update_axis,
    input  logic [1:0]        update_bank,
    input  logic [IDX_W-1:0]  update_index,
    input  logic [DATA_W-1:0] update_value,
    input  logic [1:0]        x_bank_req,
    input  logic [1:0]        y_bank_req,
    input  logic [1:0]        z_bank_req,
    input  logic              sample_strobe,
    input  logic              filter_busy,
    input  logic              clr_status,
    output logic              cw_en,
    output logic [1:0]        cw_axis,
    output logic [1:0]        cw_bank,
    output logic [IDX_W-1:0]  cw_index,
    output logic [DATA_W-1:0] cw_data,
    output logic [1:0]        x_bank,
    output logic [1:0]        y_bank,
    output logic [1:0]        z_bank,
    output logic              swap_pending,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    output logic              axis_err
);

    // Command struct field widths come from the package; the IDX_W/DATA_W
    // parameters are expected to stay at their defaults (4/16).

    logic              r_en_q;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_pop;
    logic              w_push_edge;
    logic              w_axis_bad;
    logic              w_full;
    logic              w_empty;
    logic              w_push_ok;
    logic              w_swap;
    coeff_cmd_t        w_cmd_in;
    coeff_cmd_t        w_head;

    logic              r_cw_en;
    logic [1:0]        r_cw_axis;
    logic [1:0]        r_cw_bank;
    logic [IDX_W-1:0]  r_cw_index;
    logic [DATA_W-1:0] r_cw_data;
    logic [1:0]        r_x_bank;
    logic [1:0]        r_y_bank;
    logic [1:0]        r_z_bank;
    logic              r_overflow;
    logic              r_axis_err;

    assign w_push_edge = update_en & ~r_en_q;
    assign w_axis_bad  = (update_axis == 2'd3);
    assign w_push_ok   = w_push_edge & ~w_axis_bad & ~w_full;

    assign w_cmd_in.axis  = axis_t'(update_axis);
    assign w_cmd_in.bank  = update_bank;
    assign w_cmd_in.index = update_index;
    assign w_cmd_in.value = update_value;

    // Banks only move between samples, with no writes queued or in flight and
    // no command arriving this cycle.
    assign w_swap = sample_strobe & (r_state == IDLE) & w_empty & ~w_push_ok;

    coeff_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (reset_n),
        .push    (w_push_ok),
        .pop     (w_pop),
        .wr_data (w_cmd_in),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (fifo_level)
    );

    // Strobe history for rising-edge command detection.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= update_en;
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: launch a write from IDLE when work is queued and the filter
    // is not reading; WRITE always returns to IDLE, giving one write per 2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !filter_busy) begin
                    w_state_nxt = WRITE;
                    w_pop       = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered RAM write port: head is captured as it pops, so cw_en is
    // high exactly during the WRITE cycle; fields hold afterwards.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cw_en    <= 1'b0;
            r_cw_axis  <= 2'd0;
            r_cw_bank  <= 2'd0;
            r_cw_index <= '0;
            r_cw_data  <= '0;
        end else if (w_pop) begin
            r_cw_en    <= 1'b1;
            r_cw_axis  <= w_head.axis;
            r_cw_bank  <= w_head.bank;
            r_cw_index <= w_head.index;
            r_cw_data  <= w_head.value;
        end else begin
            r_cw_en    <= 1'b0;
        end
    end

    // Active bank registers: all three axes load together on a swap.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_bank <= 2'd0;
            r_y_bank <= 2'd0;
            r_z_bank <= 2'd0;
        end else if (w_swap) begin
            r_x_bank <= x_bank_req;
            r_y_bank <= y_bank_req;
            r_z_bank <= z_bank_req;
        end
    end

    // Sticky drop flags; a set event in the same cycle as clr_status wins.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_axis_err <= 1'b0;
        end else begin
            r_overflow <= (w_push_edge & ~w_axis_bad & w_full) | (r_overflow & ~clr_status);
            r_axis_err <= (w_push_edge & w_axis_bad) | (r_axis_err & ~clr_status);
        end
    end

    assign cw_en        = r_cw_en;
    assign cw_axis      = r_cw_axis;
    assign cw_bank      = r_cw_bank;
    assign cw_index     = r_cw_index;
    assign cw_data      = r_cw_data;
    assign x_bank       = r_x_bank;
    assign y_bank       = r_y_bank;
    assign z_bank       = r_z_bank;
    assign overflow     = r_overflow;
    assign axis_err     = r_axis_err;
    assign swap_pending = (x_bank_req != r_x_bank) | (y_bank_req != r_y_bank) |
                          (z_bank_req != r_z_bank);

endmodule
